matrix_mac_seq: RTL

MATRIX_MAC_SEQ -- requirements
Module: matrix_mac_seq

---
 rtl/matrix_pkg.sv | 13 +
 rtl/matrix_mac_seq_if.sv | 26 ++
 rtl/matrix_mac_pe.sv | 52 +++++
 rtl/matrix_mac_seq.sv | 85 ++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the 2x2 matrix multiply-accumulate sequencer.
package matrix_pkg;

  localparam int ELEM_W = 4;
  localparam int RES_W  = 2*ELEM_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_mac_seq_if.sv
// Start/element/result bundle between the sequencer and whoever owns the A/B element selectors.
interface matrix_mac_seq_if #(
  parameter int ELEM_W = matrix_pkg::ELEM_W
) ();

  localparam int RES_W = 2*ELEM_W + 1;

  logic                   start;
  logic [ELEM_W-1:0]      a_elem;
  logic [ELEM_W-1:0]      b_elem;
  logic [2:0]             entry_out;
  logic                   busy;
  logic                   done;
  logic [4*RES_W-1:0]     result;

  modport master (
    output start, a_elem, b_elem,
    input  entry_out, busy, done, result
  );

  modport slave (
    input  start, a_elem, b_elem,
    output entry_out, busy, done, result
  );

endinterface

// File: rtl/matrix_mac_pe.sv
// Multiply-add element: one product per enabled cycle, summed in pairs into a RES_W accumulator.
// With MATRIX_MAC_SIGNED_EN defined the operands are two's complement, otherwise unsigned.
module matrix_mac_pe #(
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int RES_W  = 2*ELEM_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              pair_end_i,
  output logic [RES_W-1:0]  sum_o
);

  logic [RES_W-1:0] aExt;
  logic [RES_W-1:0] bExt;
  logic [RES_W-1:0] prod;
  logic [RES_W-1:0] acc_q;
  logic [RES_W-1:0] acc_d;

  // Low RES_W bits of the product are exact in both builds because every sum fits RES_W.
`ifdef MATRIX_MAC_SIGNED_EN
  assign aExt = {{(RES_W-ELEM_W){a_i[ELEM_W-1]}}, a_i};
  assign bExt = {{(RES_W-ELEM_W){b_i[ELEM_W-1]}}, b_i};
`else
  assign aExt = {{(RES_W-ELEM_W){1'b0}}, a_i};
  assign bExt = {{(RES_W-ELEM_W){1'b0}}, b_i};
`endif

  assign prod  = aExt * bExt;
  assign sum_o = acc_q + prod;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = pair_end_i ? '0 : sum_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mac_seq.sv
// 2x2 matrix multiply sequencer: walks entries 0..7, pairing products into C[0..3].
// Build option: MATRIX_MAC_SIGNED_EN selects two's-complement operands in matrix_mac_pe.
module matrix_mac_seq #(
  parameter int ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  matrix_mac_seq_if.slave   bus
);

  import matrix_pkg::*;

  localparam int RES_W = 2*ELEM_W + 1;

  state_e             state_q;
  state_e             state_d;
  logic [2:0]         entry_q;
  logic [2:0]         entry_d;
  logic [4*RES_W-1:0] result_q;
  logic [RES_W-1:0]   pairSum;
  logic               running;

  assign running = (state_q == RUN);

  matrix_mac_pe #(
    .ELEM_W (ELEM_W),
    .RES_W  (RES_W)
  ) u_pe (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_i        (bus.a_elem),
    .b_i        (bus.b_elem),
    .clr_i      (!running),
    .en_i       (running),
    .pair_end_i (entry_q[0]),
    .sum_o      (pairSum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only looked at outside RUN, so holding it high chains runs without a bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = (entry_q == 3'd7) ? DONE : RUN;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.entry_out = entry_q;
    bus.result    = result_q;
  end

  always_comb begin
    entry_d = 3'd0;
    if (running && (entry_q != 3'd7)) begin
      entry_d = entry_q + 3'd1;
    end
  end

  // Each C[k] lands on the odd entry of its pair, leaving the previous result visible until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= 3'd0;
      result_q <= '0;
    end else begin
      entry_q <= entry_d;
      if (running && entry_q[0]) begin
        result_q[entry_q[2:1]*RES_W +: RES_W] <= pairSum;
      end
    end
  end

endmodule
